// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, widths and frame helper for the SPI master
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    DONE,
    GAP
  } spi_state_e;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 16;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Read frames put zeros in the data slot; the slave drives miso there.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic              rw,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] wdata
  );
    return {addr, rw, (rw == RW_WRITE) ? wdata : {DATA_W{1'b0}}};
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - request/response handshake between on-chip logic and the SPI master
interface spi_master_ctrl_if;
  import spi_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - sck half-period counter; phase_end marks the last clk of each phase
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic phase_end
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign phase_end = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || phase_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master issuing 16-bit addr/rw/data frames, one request per frame
// Optional SPI_CS_GAP_EN: holds cs high with req_ready low for CS_GAP cycles after each frame.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_master_ctrl_if.slave   bus,
  output logic               sck,
  output logic               cs,
  output logic               mosi,
  input  logic               miso
);

  localparam logic [4:0] LAST_BIT   = 5'(FRAME_BITS - 1);
  localparam logic [4:0] DATA_FIRST = 5'(FRAME_BITS - DATA_W);

  if (CLK_DIV < 1 || CS_GAP < 1) begin : g_bad_param
    $error("spi_master_ctrl: CLK_DIV and CS_GAP must be at least 1");
  end

  spi_state_e            state;
  logic [FRAME_BITS-1:0] frame_sr;
  logic [DATA_W-1:0]     rdata_sr;
  logic [4:0]            bit_cnt;
  logic                  rw_q;
  logic                  phase_end;
  logic                  div_restart;

`ifdef SPI_CS_GAP_EN
  localparam int unsigned GAP_W = $clog2(CS_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  logic [GAP_W-1:0] gap_cnt;
`endif

  // Divider only runs while sck phases are being timed; elsewhere it is parked at zero.
  assign div_restart = !(state == SETUP || state == HIGH || state == LOW);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (div_restart),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cs            <= 1'b1;
      sck           <= 1'b0;
      mosi          <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      frame_sr      <= '0;
      rdata_sr      <= '0;
      bit_cnt       <= '0;
      rw_q          <= 1'b0;
`ifdef SPI_CS_GAP_EN
      gap_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            frame_sr      <= build_frame(bus.req_rw, bus.req_addr, bus.req_wdata);
            mosi          <= bus.req_addr[ADDR_W-1];
            rw_q          <= bus.req_rw;
            rdata_sr      <= '0;
            bit_cnt       <= '0;
            cs            <= 1'b0;
            bus.req_ready <= 1'b0;
            state         <= SETUP;
          end
        end
        SETUP: begin
          if (phase_end) begin
            sck   <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (phase_end) begin
            if (rw_q == RW_READ && bit_cnt >= DATA_FIRST) begin
              rdata_sr <= {rdata_sr[DATA_W-2:0], miso};
            end
            // Next bit goes out with the falling edge so it is stable for the whole low phase.
            frame_sr <= {frame_sr[FRAME_BITS-2:0], 1'b0};
            mosi     <= frame_sr[FRAME_BITS-2];
            sck      <= 1'b0;
            state    <= LOW;
          end
        end
        LOW: begin
          if (phase_end) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == LAST_BIT) begin
              cs            <= 1'b1;
              mosi          <= 1'b0;
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= (rw_q == RW_READ) ? rdata_sr : '0;
              state         <= DONE;
            end else begin
              sck   <= 1'b1;
              state <= HIGH;
            end
          end
        end
        DONE: begin
          bus.rsp_valid <= 1'b0;
          bit_cnt       <= '0;
`ifdef SPI_CS_GAP_EN
          gap_cnt       <= '0;
          state         <= GAP;
`else
          bus.req_ready <= 1'b1;
          state         <= IDLE;
`endif
        end
`ifdef SPI_CS_GAP_EN
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
`endif
        default: begin
          cs            <= 1'b1;
          sck           <= 1'b0;
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed bench: one DUT at CLK_DIV=2, one at CLK_DIV=1
module tb_spi_master_ctrl;

`ifdef SPI_CS_GAP_EN
  localparam int EXP_READY_DLY = 5;
  localparam int EXP_CS_HIGH   = 6;
`else
  localparam int EXP_READY_DLY = 1;
  localparam int EXP_CS_HIGH   = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  spi_master_ctrl_if if2 ();
  spi_master_ctrl_if if1 ();

  logic sck2, cs2, mosi2;
  logic miso2 = 1'b0;
  logic sck1, cs1, mosi1;
  logic miso1 = 1'b0;

  spi_master_ctrl #(.CLK_DIV(2), .CS_GAP(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2), .sck(sck2), .cs(cs2), .mosi(mosi2), .miso(miso2)
  );

  spi_master_ctrl #(.CLK_DIV(1), .CS_GAP(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .sck(sck1), .cs(cs1), .mosi(mosi1), .miso(miso1)
  );

  // Slave models: capture mosi on sck rise, drive read data on sck fall after the rw bit.
  logic [7:0]  slave_data2 = 8'h00;
  logic [7:0]  slave_data1 = 8'h00;
  logic [15:0] cap2 = '0, cap1 = '0;
  int          edges2 = 0, edges1 = 0, viol2 = 0, viol1 = 0;
  logic        prev_sck2 = 0, prev_cs2 = 1, prev_mosi2 = 0, prev_rst2 = 0;
  logic        prev_sck1 = 0, prev_cs1 = 1, prev_mosi1 = 0, prev_rst1 = 0;

  always @(negedge clk) begin
    if (rst_n && prev_rst2) begin
      if (mosi2 !== prev_mosi2 && sck2 && prev_sck2) viol2 <= viol2 + 1;
      if (cs2 !== prev_cs2 && (sck2 || prev_sck2)) viol2 <= viol2 + 1;
    end
    if (!cs2 && prev_cs2) begin
      edges2 <= 0; cap2 <= '0; miso2 <= 1'b0;
    end else if (sck2 && !prev_sck2) begin
      edges2 <= edges2 + 1; cap2 <= {cap2[14:0], mosi2};
    end else if (!sck2 && prev_sck2 && !cs2 && edges2 >= 8 && edges2 < 16) begin
      miso2 <= slave_data2[15-edges2];
    end
    prev_sck2 <= sck2; prev_cs2 <= cs2; prev_mosi2 <= mosi2; prev_rst2 <= rst_n;
  end

  always @(negedge clk) begin
    if (rst_n && prev_rst1) begin
      if (mosi1 !== prev_mosi1 && sck1 && prev_sck1) viol1 <= viol1 + 1;
      if (cs1 !== prev_cs1 && (sck1 || prev_sck1)) viol1 <= viol1 + 1;
    end
    if (!cs1 && prev_cs1) begin
      edges1 <= 0; cap1 <= '0; miso1 <= 1'b0;
    end else if (sck1 && !prev_sck1) begin
      edges1 <= edges1 + 1; cap1 <= {cap1[14:0], mosi1};
    end else if (!sck1 && prev_sck1 && !cs1 && edges1 >= 8 && edges1 < 16) begin
      miso1 <= slave_data1[15-edges1];
    end
    prev_sck1 <= sck1; prev_cs1 <= cs1; prev_mosi1 <= mosi1; prev_rst1 <= rst_n;
  end

  task automatic start2(input logic rw, input logic [6:0] addr, input logic [7:0] wdata);
    repeat (8) @(negedge clk);
    if2.req_rw = rw; if2.req_addr = addr; if2.req_wdata = wdata; if2.req_valid = 1'b1;
    n_cmp++;
    if (if2.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL start_ready: req_ready=%b want 1", if2.req_ready);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (cs2 !== 1'b1) begin n_fail++; $display("FAIL rst_cs: got %b want 1", cs2); end
    n_cmp++; if (sck2 !== 1'b0) begin n_fail++; $display("FAIL rst_sck: got %b want 0", sck2); end
    n_cmp++; if (mosi2 !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %b want 0", mosi2); end
    n_cmp++; if (if2.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", if2.rsp_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (if2.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", if2.req_ready); end
    n_cmp++; if (if2.rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h want 00", if2.rsp_rdata); end
    n_cmp++; if (if1.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready1: got %b want 1", if1.req_ready); end
  endtask

  task automatic test_write();
    int cyc;
    start2(1'b0, 7'h2A, 8'hC3);
    cyc = 0;
    do begin @(negedge clk); if2.req_valid = 1'b0; cyc++; end
    while (if2.rsp_valid !== 1'b1 && cyc < 200);
    n_cmp++; if (cyc != 67) begin n_fail++; $display("FAIL wr_latency: got %0d want 67", cyc); end
    n_cmp++; if (if2.rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL wr_rdata: got %h want 00", if2.rsp_rdata); end
    n_cmp++; if (cap2 !== 16'h54C3) begin n_fail++; $display("FAIL wr_mosi: got %h want 54c3", cap2); end
    n_cmp++; if (edges2 != 16) begin n_fail++; $display("FAIL wr_sck_pulses: got %0d want 16", edges2); end
    @(negedge clk);
    n_cmp++; if (if2.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_pulse: got %b want 0", if2.rsp_valid); end
  endtask

  task automatic test_read();
    int cyc;
    slave_data2 = 8'hA5;
    start2(1'b1, 7'h05, 8'hFF);
    cyc = 0;
    do begin @(negedge clk); if2.req_valid = 1'b0; cyc++; end
    while (if2.rsp_valid !== 1'b1 && cyc < 200);
    n_cmp++; if (cyc != 67) begin n_fail++; $display("FAIL rd_latency: got %0d want 67", cyc); end
    n_cmp++; if (if2.rsp_rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_rdata: got %h want a5", if2.rsp_rdata); end
    n_cmp++; if (cap2 !== 16'h0B00) begin n_fail++; $display("FAIL rd_mosi: got %h want 0b00", cap2); end
    @(negedge clk);
    n_cmp++; if (if2.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_rsp_pulse: got %b want 0", if2.rsp_valid); end
    repeat (3) @(negedge clk);
    n_cmp++; if (if2.rsp_rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_rdata_hold: got %h want a5", if2.rsp_rdata); end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    start2(1'b0, 7'h33, 8'h5A);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if2.req_valid = (cyc < 60) ? cyc[0] : 1'b0;
      if2.req_addr = 7'h7F; if2.req_rw = 1'b1; if2.req_wdata = 8'hFF;
    end while (if2.rsp_valid !== 1'b1 && cyc < 200);
    n_cmp++; if (cyc != 67) begin n_fail++; $display("FAIL busy_latency: got %0d want 67", cyc); end
    n_cmp++; if (cap2 !== 16'h665A) begin n_fail++; $display("FAIL busy_mosi: got %h want 665a", cap2); end
    n_cmp++; if (viol2 != 0) begin n_fail++; $display("FAIL busy_edge_rules: got %0d violations want 0", viol2); end
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    bit saw_rsp;
    start2(1'b0, 7'h2A, 8'hC3);
    cyc = 0;
    do begin @(negedge clk); if2.req_valid = 1'b0; cyc++; end
    while (!(edges2 == 6 && sck2 === 1'b1) && cyc < 200);
    n_cmp++; if (mosi2 !== 1'b1) begin n_fail++; $display("FAIL mid_pre_mosi: got %b want 1", mosi2); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cs2 !== 1'b1) begin n_fail++; $display("FAIL mid_cs: got %b want 1", cs2); end
    n_cmp++; if (sck2 !== 1'b0) begin n_fail++; $display("FAIL mid_sck: got %b want 0", sck2); end
    n_cmp++; if (mosi2 !== 1'b0) begin n_fail++; $display("FAIL mid_mosi: got %b want 0", mosi2); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (if2.req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", if2.req_ready); end
    saw_rsp = 1'b0;
    repeat (80) begin @(negedge clk); if (if2.rsp_valid !== 1'b0) saw_rsp = 1'b1; end
    n_cmp++; if (saw_rsp) begin n_fail++; $display("FAIL mid_no_rsp: got rsp_valid pulse want none"); end
  endtask

  task automatic test_back_to_back();
    int cyc, d, cs_hi;
    slave_data1 = 8'h3C;
    repeat (8) @(negedge clk);
    if1.req_rw = 1'b1; if1.req_addr = 7'h11; if1.req_wdata = 8'h00; if1.req_valid = 1'b1;
    @(posedge clk);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (if1.rsp_valid !== 1'b1 && cyc < 100);
    n_cmp++; if (cyc != 34) begin n_fail++; $display("FAIL b2b_lat1: got %0d want 34", cyc); end
    n_cmp++; if (if1.rsp_rdata !== 8'h3C) begin n_fail++; $display("FAIL b2b_rdata1: got %h want 3c", if1.rsp_rdata); end
    n_cmp++; if (cap1 !== 16'h2300) begin n_fail++; $display("FAIL b2b_mosi1: got %h want 2300", cap1); end
    slave_data1 = 8'h96;
    cs_hi = (cs1 === 1'b1) ? 1 : 0;
    d = 0;
    do begin @(negedge clk); d++; if (cs1 === 1'b1) cs_hi++; end
    while (if1.req_ready !== 1'b1 && d < 20);
    n_cmp++; if (d != EXP_READY_DLY) begin n_fail++; $display("FAIL b2b_ready_dly: got %0d want %0d", d, EXP_READY_DLY); end
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk); if1.req_valid = 1'b0; cyc++;
      if (cs1 === 1'b1 && cyc == 1) cs_hi++;
    end while (if1.rsp_valid !== 1'b1 && cyc < 100);
    n_cmp++; if (cs_hi != EXP_CS_HIGH) begin n_fail++; $display("FAIL b2b_cs_high: got %0d want %0d", cs_hi, EXP_CS_HIGH); end
    n_cmp++; if (cyc != 34) begin n_fail++; $display("FAIL b2b_lat2: got %0d want 34", cyc); end
    n_cmp++; if (if1.rsp_rdata !== 8'h96) begin n_fail++; $display("FAIL b2b_rdata2: got %h want 96", if1.rsp_rdata); end
    n_cmp++; if (cap1 !== 16'h2300) begin n_fail++; $display("FAIL b2b_mosi2: got %h want 2300", cap1); end
    n_cmp++; if (viol1 != 0) begin n_fail++; $display("FAIL b2b_edge_rules: got %0d violations want 0", viol1); end
  endtask

  initial begin
    if2.req_valid = 1'b0; if2.req_rw = 1'b0; if2.req_addr = '0; if2.req_wdata = '0;
    if1.req_valid = 1'b0; if1.req_rw = 1'b0; if1.req_addr = '0; if1.req_wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_busy_ignore();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
